// File: rtl/banco_registros_pkg.sv
// Shared definitions for the integer register bank: sweep FSM states,
// address-width helper and the default geometry also used by decode.
package banco_registros_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Address bits needed to cover depth entries; never narrower than 1 bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/banco_registros_if.sv
// Register bank port bundle: one write port, two read ports, sweep control.
// Handshake: there is no valid/ready pair. A write is a single-cycle request
// (enable) that the bank either accepts at the rising edge or silently drops
// (busy high, address out of range, or hardwired entry 0); reads are
// combinational and always valid; sweep_req is sampled only while busy is low.
interface banco_registros_if
  import banco_registros_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = addr_width(DEF_DEPTH)
);
  logic             enable;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             sweep_req;
  logic             busy;
  sweep_state_e     dbg_state;

  modport master (
    output enable, wr_addr, wr_data, rd_addr_a, rd_addr_b, sweep_req,
    input  rd_data_a, rd_data_b, busy, dbg_state
  );

  modport slave (
    input  enable, wr_addr, wr_data, rd_addr_a, rd_addr_b, sweep_req,
    output rd_data_a, rd_data_b, busy, dbg_state
  );
endinterface

// File: rtl/banco_registros_sweep.sv
// Clear-sweep sequencer: walks the entry index from 0 to DEPTH-1, one entry
// per cycle, then returns to IDLE. Requests arriving mid-sweep are dropped.
module banco_registros_sweep
  import banco_registros_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_width(DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          clearN,
  input  logic          sweep_req_i,
  output logic          busy_o,
  output logic          sweep_en_o,
  output logic [AW-1:0] sweep_addr_o,
  output sweep_state_e  state_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any sweep in flight.
  always_ff @(posedge clk) begin
    if (!clearN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start on request in IDLE, leave after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sweep_req_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o       = (state_q == SWEEP);
  assign sweep_en_o   = (state_q == SWEEP);
  assign sweep_addr_o = cnt_q;
  assign state_o      = state_q;

endmodule

// File: rtl/banco_registros.sv
// Integer register file: DEPTH x WIDTH storage, two combinational read
// ports, one synchronous write port, optional hardwired-zero entry 0,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             clearN,
  banco_registros_if.slave bus
);

  localparam int AW = addr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             busy;
  logic             sweep_en;
  logic [AW-1:0]    sweep_addr;
  logic             wr_accept;

  banco_registros_sweep #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sweep (
    .clk          (clk),
    .clearN       (clearN),
    .sweep_req_i  (bus.sweep_req),
    .busy_o       (busy),
    .sweep_en_o   (sweep_en),
    .sweep_addr_o (sweep_addr),
    .state_o      (bus.dbg_state)
  );

  // Addresses beyond DEPTH exist when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  // Read mux priority: out of range, hardwired zero, bypass, storage.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
    if (!in_range(a))
      return '0;
    else if (ZERO_REG != 0 && a == '0)
      return '0;
    else if (BYPASS != 0 && wr_accept && bus.wr_addr == a)
      return bus.wr_data;
    else
      return mem_q[a];
  endfunction

  // A sweep blocks writes, so sweep and write never target storage together.
  always_comb begin
    wr_accept = bus.enable && !busy && in_range(bus.wr_addr) &&
                !(ZERO_REG != 0 && bus.wr_addr == '0);
  end

  // Storage: reset clears everything, otherwise sweep zeroing or a write.
  always_ff @(posedge clk) begin
    if (!clearN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (sweep_en) mem_q[sweep_addr] <= '0;
      if (wr_accept) mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.rd_data_a = read_port(bus.rd_addr_a);
  assign bus.rd_data_b = read_port(bus.rd_addr_b);
  assign bus.busy      = busy;

endmodule

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros: random traffic against a
// behavioural register-file model, directed test-plan scenarios, and a
// second instance with DEPTH = 24.
module tb_banco_registros;
  import banco_registros_pkg::*;

  localparam int W    = 32;
  localparam int D    = 32;
  localparam int AW   = addr_width(D);
  localparam int D24  = 24;
  localparam int AW24 = addr_width(D24);

  logic clk      = 1'b0;
  logic clearN   = 1'b0;
  logic clearN24 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  banco_registros_if #(.WIDTH(W), .AW(AW))   bus();
  banco_registros_if #(.WIDTH(W), .AW(AW24)) bus24();

  banco_registros #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk    (clk),
    .clearN (clearN),
    .bus    (bus)
  );

  banco_registros #(.WIDTH(W), .DEPTH(D24), .ZERO_REG(1), .BYPASS(1)) dut24 (
    .clk    (clk),
    .clearN (clearN24),
    .bus    (bus24)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] ref_mem [D];
  bit           ref_busy;
  int           ref_pos;
  bit           obs_busy;

  function automatic bit accepted();
    return bus.enable && !ref_busy && (int'(bus.wr_addr) < D) && (bus.wr_addr != 0);
  endfunction

  function automatic logic [W-1:0] ref_read(input int a);
    if (a >= D || a == 0) return '0;
    if (accepted() && int'(bus.wr_addr) == a) return bus.wr_data;
    return ref_mem[a];
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    ref_busy = 1'b0;
    ref_pos  = 0;
  endtask

  // One clock cycle: check outputs before the edge, advance the model at it.
  task automatic tick();
    bit acc;
    #1;
    exp_q.push_back(ref_read(int'(bus.rd_addr_a)));
    exp_q.push_back(ref_read(int'(bus.rd_addr_b)));
    chk("rd_data_a", bus.rd_data_a, exp_q.pop_front());
    chk("rd_data_b", bus.rd_data_b, exp_q.pop_front());
    chk("busy", W'(bus.busy), W'(ref_busy));
    obs_busy = bus.busy;
    acc = accepted();
    @(posedge clk);
    if (!clearN) begin
      ref_clear();
    end else if (ref_busy) begin
      ref_mem[ref_pos] = '0;
      if (ref_pos == D - 1) begin
        ref_busy = 1'b0;
        ref_pos  = 0;
      end else begin
        ref_pos++;
      end
    end else begin
      if (acc) ref_mem[bus.wr_addr] = bus.wr_data;
      if (bus.sweep_req) begin
        ref_busy = 1'b1;
        ref_pos  = 0;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.enable    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.sweep_req = 1'b0;
  endtask

  task automatic write(input int a, input logic [W-1:0] d);
    bus.enable    = 1'b1;
    bus.wr_addr   = AW'(a);
    bus.wr_data   = d;
    bus.rd_addr_a = AW'(a);
    tick();
    bus.enable = 1'b0;
  endtask

  task automatic expect_a(input string tag, input int a, input logic [W-1:0] e);
    bus.enable    = 1'b0;
    bus.sweep_req = 1'b0;
    bus.rd_addr_a = AW'(a);
    #1;
    chk(tag, bus.rd_data_a, e);
    tick();
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < D; a++) begin
      bus.enable    = 1'b0;
      bus.rd_addr_a = AW'(a);
      bus.rd_addr_b = AW'(D - 1 - a);
      #1;
      chk(tag, bus.rd_data_a, '0);
      tick();
    end
  endtask

  task automatic fill_index();
    for (int a = 1; a < D; a++) write(a, W'(a));
  endtask

  // Pulse sweep_req, then count busy cycles (bounded). Optional mid-sweep
  // blocked write to addr 9, re-pulse and reset at the given loop indices.
  task automatic run_sweep(input int hit_at, input int repulse_at, input int reset_at,
                           output int n);
    bus.sweep_req = 1'b1;
    tick();
    bus.sweep_req = 1'b0;
    bus.enable    = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      bus.enable    = (k == hit_at);
      bus.wr_addr   = AW'(9);
      bus.wr_data   = 32'h0000_AAAA;
      bus.sweep_req = (k == repulse_at);
      clearN        = (k != reset_at);
      bus.rd_addr_a = AW'(3);
      bus.rd_addr_b = AW'(31);
      tick();
      if (!obs_busy) break;
      n++;
    end
    clearN        = 1'b1;
    bus.enable    = 1'b0;
    bus.sweep_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    drive_idle();
    bus24.enable    = 1'b0;
    bus24.wr_addr   = '0;
    bus24.wr_data   = '0;
    bus24.rd_addr_a = '0;
    bus24.rd_addr_b = '0;
    bus24.sweep_req = 1'b0;
    ref_clear();

    // Reset and hardwired zero
    clearN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clearN = 1'b1;
    read_all_zero("reset_zero");
    write(0, 32'hDEAD_BEEF);
    expect_a("zero_reg", 0, '0);

    // Write/read and bypass
    write(5, 32'h1234_5678);
    expect_a("wr_rd_5", 5, 32'h1234_5678);
    bus.enable    = 1'b1;
    bus.wr_addr   = AW'(7);
    bus.wr_data   = 32'hCAFE_F00D;
    bus.rd_addr_b = AW'(7);
    #1;
    chk("bypass_b", bus.rd_data_b, 32'hCAFE_F00D);
    tick();
    bus.enable = 1'b0;
    expect_a("stored_7", 7, 32'hCAFE_F00D);

    // Randomized traffic including occasional sweeps and resets
    for (int i = 0; i < 400; i++) begin
      bus.enable    = 1'($urandom_range(0, 1));
      bus.wr_addr   = AW'($urandom_range(0, D - 1));
      bus.wr_data   = $urandom;
      bus.rd_addr_a = ($urandom_range(0, 1) == 1) ? bus.wr_addr : AW'($urandom_range(0, D - 1));
      bus.rd_addr_b = AW'($urandom_range(0, D - 1));
      bus.sweep_req = ($urandom_range(0, 39) == 0);
      clearN        = ($urandom_range(0, 99) != 0);
      tick();
    end
    clearN = 1'b1;
    drive_idle();
    for (int i = 0; i < 40; i++) tick();

    // Full sweep with blocked write to 9 and a mid-sweep re-pulse
    fill_index();
    run_sweep(5, 12, -1, n);
    chk("sweep_len", W'(n), W'(D));
    expect_a("blocked_9", 9, '0);
    read_all_zero("after_sweep");

    // Sweep request together with a write to addr 2
    fill_index();
    bus.enable  = 1'b1;
    bus.wr_addr = AW'(2);
    bus.wr_data = 32'h55;
    run_sweep(-1, -1, -1, n);
    chk("collide_len", W'(n), W'(D));
    expect_a("collide_2", 2, '0);

    // Reset in the middle of a sweep, then a full new sweep
    fill_index();
    run_sweep(-1, -1, 10, n);
    chk("abort_len", W'(n), W'(11));
    read_all_zero("after_abort");
    fill_index();
    run_sweep(-1, -1, -1, n);
    chk("resweep_len", W'(n), W'(D));

    // Non-power-of-two depth instance
    clearN24 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clearN24        = 1'b1;
    bus24.enable    = 1'b1;
    bus24.wr_addr   = AW24'(30);
    bus24.wr_data   = 32'h77;
    bus24.rd_addr_a = AW24'(30);
    bus24.rd_addr_b = AW24'(30);
    #1;
    chk("d24_rd30_a", bus24.rd_data_a, '0);
    chk("d24_rd30_b", bus24.rd_data_b, '0);
    @(posedge clk);
    @(negedge clk);
    bus24.wr_addr = AW24'(4);
    bus24.wr_data = 32'h44;
    @(posedge clk);
    @(negedge clk);
    bus24.enable    = 1'b0;
    bus24.rd_addr_a = AW24'(4);
    #1;
    chk("d24_rd4", bus24.rd_data_a, 32'h44);
    chk("d24_rd30_after", bus24.rd_data_b, '0);
    bus24.sweep_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus24.sweep_req = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!bus24.busy) break;
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("d24_sweep_len", W'(n), W'(D24));
    #1;
    chk("d24_swept4", bus24.rd_data_a, '0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
